color_bbox_tracker: RTL and testbench



---
 rtl/color_bbox_tracker.sv | 231 +++++++++++++++++++++++
 tb/tb_color_bbox_tracker.sv | 253 +++++++++++++++++++++++++
 2 files changed

// File: rtl/color_bbox_tracker.sv
// Multi-target colour tracker: per-frame min/max bounding boxes.
// Option macro: TRACK_PIXEL_COUNT_EN (matched-pixel counters, MIN_PIXELS).
module color_bbox_tracker #(
  parameter int WIDTH       = 640,
  parameter int HEIGHT      = 480,
  parameter int NUM_TARGETS = 2,
  parameter int COORD_W     = 12,
  parameter int CNT_W       = 20,
  parameter int MIN_PIXELS  = 16
) (
  input  logic                           clock_50,
  input  logic                           reset,
  input  logic                           in_valid,
  output logic                           in_ready,
  input  logic                           in_sof,
  input  logic [23:0]                    in_pixel,
  input  logic [24*NUM_TARGETS-1:0]      thr_lo,
  input  logic [24*NUM_TARGETS-1:0]      thr_hi,
  output logic                           out_valid,
  input  logic                           out_ready,
  output logic [NUM_TARGETS-1:0]         out_found,
  output logic [COORD_W*NUM_TARGETS-1:0] out_center_x,
  output logic [COORD_W*NUM_TARGETS-1:0] out_center_y,
  output logic [COORD_W*NUM_TARGETS-1:0] out_width,
  output logic [COORD_W*NUM_TARGETS-1:0] out_height,
  output logic [CNT_W*NUM_TARGETS-1:0]   out_count,
  output logic                           overrun,
  output logic                           resync
);

  localparam int NT = NUM_TARGETS;
  localparam logic [COORD_W-1:0] XL = COORD_W'(WIDTH - 1);
  localparam logic [COORD_W-1:0] YL = COORD_W'(HEIGHT - 1);

  if (NT < 1 || NT > 4 || MIN_PIXELS < 0) begin : g_bad_cfg
    $error("color_bbox_tracker: unsupported parameters");
  end

  function automatic logic in_win(input logic [7:0] c,
                                  input logic [7:0] lo,
                                  input logic [7:0] hi);
    return (c >= lo) && (c <= hi);
  endfunction

  logic               accept;
  logic [COORD_W-1:0] x_cnt, y_cnt;
  logic [COORD_W-1:0] cur_x, cur_y;
  logic               cur_first, x_end, y_end;

  logic [24*NT-1:0]   lo_sh, hi_sh;

  logic               s1_valid, s1_first, s1_last;
  logic [23:0]        s1_pix;
  logic [COORD_W-1:0] s1_x, s1_y;

  logic [NT-1:0]      m;
  logic [NT-1:0]      seen;
  logic [NT-1:0][COORD_W-1:0] xmin, xmax, ymin, ymax;
  logic               s2_last;

  logic [NT-1:0]         fin_found;
  logic [COORD_W*NT-1:0] fin_cx, fin_cy, fin_w, fin_h;
  logic [CNT_W*NT-1:0]   fin_cnt;
  logic [NT-1:0]         found;

  assign in_ready = reset;
  assign accept   = in_valid & in_ready;

  // Coordinate of the pixel being offered; sof forces it to the origin
  always_comb begin
    cur_x     = in_sof ? '0 : x_cnt;
    cur_y     = in_sof ? '0 : y_cnt;
    cur_first = (cur_x == '0) && (cur_y == '0);
    x_end     = (cur_x == XL);
    y_end     = (cur_y == YL);
  end

  // Raster counters, threshold shadows, resync flag and stage-1 register
  always_ff @(posedge clock_50 or negedge reset) begin
    if (!reset) begin
      x_cnt    <= '0;
      y_cnt    <= '0;
      lo_sh    <= '0;
      hi_sh    <= '0;
      resync   <= 1'b0;
      s1_valid <= 1'b0;
      s1_first <= 1'b0;
      s1_last  <= 1'b0;
      s1_pix   <= '0;
      s1_x     <= '0;
      s1_y     <= '0;
    end else begin
      s1_valid <= accept;
      if (accept) begin
        x_cnt    <= x_end ? '0 : cur_x + 1'b1;
        y_cnt    <= x_end ? (y_end ? '0 : cur_y + 1'b1) : cur_y;
        s1_pix   <= in_pixel;
        s1_x     <= cur_x;
        s1_y     <= cur_y;
        s1_first <= cur_first;
        s1_last  <= x_end && y_end;
        if (cur_first) begin
          lo_sh <= thr_lo;
          hi_sh <= thr_hi;
        end
        if (in_sof && (x_cnt != '0 || y_cnt != '0))
          resync <= 1'b1;
      end
    end
  end

  // Per-target inclusive RGB window test on the stage-1 pixel
  always_comb begin
    m = '0;
    for (int k = 0; k < NT; k++) begin
      m[k] = in_win(s1_pix[23:16], lo_sh[24*k+16 +: 8], hi_sh[24*k+16 +: 8])
          && in_win(s1_pix[15:8],  lo_sh[24*k+8  +: 8], hi_sh[24*k+8  +: 8])
          && in_win(s1_pix[7:0],   lo_sh[24*k    +: 8], hi_sh[24*k    +: 8]);
    end
  end

  // Stage 2: bounding-box accumulators, restarted by the frame's first pixel
  always_ff @(posedge clock_50 or negedge reset) begin
    if (!reset) begin
      seen    <= '0;
      xmin    <= '0;
      xmax    <= '0;
      ymin    <= '0;
      ymax    <= '0;
      s2_last <= 1'b0;
    end else begin
      s2_last <= s1_valid && s1_last;
      if (s1_valid) begin
        for (int k = 0; k < NT; k++) begin
          if (s1_first || (m[k] && !seen[k])) begin
            seen[k] <= m[k];
            xmin[k] <= m[k] ? s1_x : '0;
            xmax[k] <= m[k] ? s1_x : '0;
            ymin[k] <= m[k] ? s1_y : '0;
            ymax[k] <= m[k] ? s1_y : '0;
          end else if (m[k]) begin
            if (s1_x < xmin[k]) xmin[k] <= s1_x;
            if (s1_x > xmax[k]) xmax[k] <= s1_x;
            if (s1_y < ymin[k]) ymin[k] <= s1_y;
            if (s1_y > ymax[k]) ymax[k] <= s1_y;
          end
        end
      end
    end
  end

`ifdef TRACK_PIXEL_COUNT_EN
  logic [NT-1:0][CNT_W-1:0] cnt;

  // Saturating matched-pixel counters
  always_ff @(posedge clock_50 or negedge reset) begin
    if (!reset) begin
      cnt <= '0;
    end else if (s1_valid) begin
      for (int k = 0; k < NT; k++) begin
        if (s1_first)
          cnt[k] <= m[k] ? CNT_W'(1) : '0;
        else if (m[k] && cnt[k] != '1)
          cnt[k] <= cnt[k] + 1'b1;
      end
    end
  end

  // A target counts as found once enough pixels matched
  always_comb begin
    found = '0;
    for (int k = 0; k < NT; k++)
      found[k] = (cnt[k] >= CNT_W'(MIN_PIXELS));
  end
`else
  assign found = seen;
`endif

  // Frame result fields; unfound targets report zeros
  always_comb begin
    fin_found = '0;
    fin_cx    = '0;
    fin_cy    = '0;
    fin_w     = '0;
    fin_h     = '0;
    fin_cnt   = '0;
    for (int k = 0; k < NT; k++) begin
      if (found[k]) begin
        fin_found[k] = 1'b1;
        fin_cx[COORD_W*k +: COORD_W] =
          COORD_W'(({1'b0, xmin[k]} + {1'b0, xmax[k]}) >> 1);
        fin_cy[COORD_W*k +: COORD_W] =
          COORD_W'(({1'b0, ymin[k]} + {1'b0, ymax[k]}) >> 1);
        fin_w[COORD_W*k +: COORD_W] = xmax[k] - xmin[k] + 1'b1;
        fin_h[COORD_W*k +: COORD_W] = ymax[k] - ymin[k] + 1'b1;
`ifdef TRACK_PIXEL_COUNT_EN
        fin_cnt[CNT_W*k +: CNT_W] = cnt[k];
`endif
      end
    end
  end

  // Result port: load when free or being drained, else drop and flag
  always_ff @(posedge clock_50 or negedge reset) begin
    if (!reset) begin
      out_valid    <= 1'b0;
      out_found    <= '0;
      out_center_x <= '0;
      out_center_y <= '0;
      out_width    <= '0;
      out_height   <= '0;
      out_count    <= '0;
      overrun      <= 1'b0;
    end else if (s2_last) begin
      if (!out_valid || out_ready) begin
        out_valid    <= 1'b1;
        out_found    <= fin_found;
        out_center_x <= fin_cx;
        out_center_y <= fin_cy;
        out_width    <= fin_w;
        out_height   <= fin_h;
        out_count    <= fin_cnt;
      end else begin
        overrun <= 1'b1;
      end
    end else if (out_valid && out_ready) begin
      out_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_color_bbox_tracker.sv
// Bench for color_bbox_tracker on an 8x4 raster, two targets.
// Table of frames plus handshake, overrun, resync and reset sequences.
module tb_color_bbox_tracker;

  localparam int W    = 8;
  localparam int H    = 4;
  localparam int NT   = 2;
  localparam int CW   = 12;
  localparam int NW   = 20;
  localparam int MINP = 16;

  logic          clock_50;
  logic          reset;
  logic          in_valid;
  logic          in_ready;
  logic          in_sof;
  logic [23:0]   in_pixel;
  logic [47:0]   thr_lo, thr_hi;
  logic          out_valid;
  logic          out_ready;
  logic [1:0]    out_found;
  logic [23:0]   out_center_x, out_center_y, out_width, out_height;
  logic [39:0]   out_count;
  logic          overrun;
  logic          resync;

  color_bbox_tracker #(
    .WIDTH(W), .HEIGHT(H), .NUM_TARGETS(NT),
    .COORD_W(CW), .CNT_W(NW), .MIN_PIXELS(MINP)
  ) dut (
    .clock_50(clock_50), .reset(reset),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_sof(in_sof), .in_pixel(in_pixel),
    .thr_lo(thr_lo), .thr_hi(thr_hi),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_found(out_found),
    .out_center_x(out_center_x), .out_center_y(out_center_y),
    .out_width(out_width), .out_height(out_height),
    .out_count(out_count),
    .overrun(overrun), .resync(resync)
  );

  initial clock_50 = 1'b0;
  always #10 clock_50 = ~clock_50;

  // frame: thresholds, background, two painted rectangles, expected box data
  typedef struct {
    logic [23:0] lo0, hi0, lo1, hi1, bg;
    int ax0, ax1, ay0, ay1; logic [23:0] ac;
    int bx0, bx1, by0, by1; logic [23:0] bc;
    logic [1:0] seen;
    int cx0, cy0, w0, h0, n0;
    int cx1, cy1, w1, h1, n1;
  } vec_t;

  typedef struct {
    string       tag;
    logic [1:0]  found;
    logic [23:0] cx, cy, w, h;
    logic [39:0] cnt;
  } res_t;

  vec_t vt[5];
  res_t q[$];
  int   nvec = 0;
  int   nfail = 0;

  task automatic chk(input string nm, input logic [39:0] act,
                     input logic [39:0] exp);
    nvec++;
    if (act !== exp) begin
      nfail++;
      $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
    end
  endtask

  function automatic res_t expect_of(input vec_t v, input string tag);
    res_t r;
    int cx[2], cy[2], w[2], h[2], n[2];
    logic f;
    cx = '{v.cx0, v.cx1}; cy = '{v.cy0, v.cy1};
    w  = '{v.w0, v.w1};   h  = '{v.h0, v.h1};
    n  = '{v.n0, v.n1};
    r.tag = tag; r.found = '0;
    r.cx = '0; r.cy = '0; r.w = '0; r.h = '0; r.cnt = '0;
    for (int k = 0; k < 2; k++) begin
`ifdef TRACK_PIXEL_COUNT_EN
      f = (n[k] >= MINP);
`else
      f = v.seen[k];
`endif
      if (f) begin
        r.found[k] = 1'b1;
        r.cx[12*k +: 12] = 12'(cx[k]);
        r.cy[12*k +: 12] = 12'(cy[k]);
        r.w[12*k +: 12]  = 12'(w[k]);
        r.h[12*k +: 12]  = 12'(h[k]);
`ifdef TRACK_PIXEL_COUNT_EN
        r.cnt[20*k +: 20] = 20'(n[k]);
`endif
      end
    end
    return r;
  endfunction

  function automatic logic [23:0] color_at(input vec_t v, input int x,
                                           input int y);
    if (x >= v.ax0 && x <= v.ax1 && y >= v.ay0 && y <= v.ay1) return v.ac;
    if (x >= v.bx0 && x <= v.bx1 && y >= v.by0 && y <= v.by1) return v.bc;
    return v.bg;
  endfunction

  task automatic send_frame(input int vi, input bit sof, input bit push,
                            input int npix, input string tag);
    thr_lo = {vt[vi].lo1, vt[vi].lo0};
    thr_hi = {vt[vi].hi1, vt[vi].hi0};
    for (int i = 0; i < npix; i++) begin
      in_valid = 1'b1;
      in_sof   = sof && (i == 0);
      in_pixel = color_at(vt[vi], i % W, i / W);
      if (push && i == W*H-1) q.push_back(expect_of(vt[vi], tag));
      @(posedge clock_50); #1;
    end
    in_valid = 1'b0;
    in_sof   = 1'b0;
  endtask

  // scoreboard: compare every accepted result against the queue head
  always @(negedge clock_50) begin : mon
    res_t e;
    if (reset && out_valid && out_ready) begin
      if (q.size() == 0) begin
        nvec++;
        nfail++;
        $display("FAIL unexpected_result: got found=%0h, expected none",
                 out_found);
      end else begin
        e = q.pop_front();
        chk({e.tag, "_found"}, 40'(out_found), 40'(e.found));
        for (int k = 0; k < 2; k++) begin
          chk($sformatf("%s_cx%0d", e.tag, k),
              40'(out_center_x[12*k +: 12]), 40'(e.cx[12*k +: 12]));
          chk($sformatf("%s_cy%0d", e.tag, k),
              40'(out_center_y[12*k +: 12]), 40'(e.cy[12*k +: 12]));
          chk($sformatf("%s_w%0d", e.tag, k),
              40'(out_width[12*k +: 12]), 40'(e.w[12*k +: 12]));
          chk($sformatf("%s_h%0d", e.tag, k),
              40'(out_height[12*k +: 12]), 40'(e.h[12*k +: 12]));
          chk($sformatf("%s_cnt%0d", e.tag, k),
              40'(out_count[20*k +: 20]), 40'(e.cnt[20*k +: 20]));
        end
      end
    end
  end

  initial begin : watchdog
    #400000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1);
  end

  initial begin
    reset = 1'b0; in_valid = 1'b0; in_sof = 1'b0; in_pixel = '0;
    thr_lo = '0; thr_hi = '0; out_ready = 1'b1;

    vt[0] = '{24'h003200, 24'h32FF32, 24'hFFFFFF, 24'h000000, 24'h0,
              2, 2, 1, 1, 24'h00C800, 5, 5, 3, 3, 24'h323232, 2'b01,
              3, 2, 4, 3, 2, 0, 0, 0, 0, 0};
    vt[1] = '{24'h640000, 24'hFF3232, 24'h000064, 24'h3232FF, 24'h0,
              3, 4, 0, 1, 24'hC80000, 7, 7, 3, 3, 24'h0000C8, 2'b11,
              3, 0, 2, 2, 4, 7, 3, 1, 1, 1};
    vt[2] = '{24'h640000, 24'hFF3232, 24'h000064, 24'h3232FF, 24'h0,
              0, 3, 0, 1, 24'h808080, 6, 7, 2, 3, 24'h808080, 2'b00,
              0, 0, 0, 0, 0, 0, 0, 0, 0, 0};
    vt[3] = '{24'h003200, 24'h32FF32, 24'hFFFFFF, 24'h000000, 24'h0,
              0, 7, 0, 0, 24'h00C800, 0, 6, 1, 1, 24'h00C800, 2'b01,
              3, 0, 8, 2, 15, 0, 0, 0, 0, 0};
    vt[4] = '{24'h003200, 24'h32FF32, 24'h000064, 24'h3232FF, 24'h00FF00,
              0, 0, 0, 0, 24'h0000FF, 7, 7, 3, 3, 24'h0000FF, 2'b11,
              3, 1, 8, 4, 30, 3, 1, 8, 4, 2};

    repeat (3) @(posedge clock_50); #1;
    chk("rst_in_ready", 40'(in_ready), 40'd0);
    chk("rst_out_valid", 40'(out_valid), 40'd0);
    chk("rst_found", 40'(out_found), 40'd0);
    chk("rst_count", out_count, 40'd0);
    chk("rst_overrun", 40'(overrun), 40'd0);
    chk("rst_resync", 40'(resync), 40'd0);
    reset = 1'b1; #1;
    chk("run_in_ready", 40'(in_ready), 40'd1);
    @(posedge clock_50); #1;

    // result latency: two edges after the last pixel is accepted
    send_frame(0, 1'b1, 1'b1, W*H, "v0");
    chk("lat_e0", 40'(out_valid), 40'd0);
    @(posedge clock_50); #1;
    chk("lat_e1", 40'(out_valid), 40'd0);
    @(posedge clock_50); #1;
    chk("lat_e2", 40'(out_valid), 40'd1);
    repeat (3) @(posedge clock_50); #1;
    chk("lat_drop", 40'(out_valid), 40'd0);

    // back-to-back frames from the table
    for (int vi = 1; vi < 5; vi++)
      send_frame(vi, 1'b1, 1'b1, W*H, $sformatf("v%0d", vi));
    repeat (5) @(posedge clock_50); #1;
    chk("bb_resync", 40'(resync), 40'd0);
    chk("bb_overrun", 40'(overrun), 40'd0);

    // consumer stalls across two frames
    out_ready = 1'b0;
    send_frame(1, 1'b1, 1'b1, W*H, "ovA");
    repeat (3) @(posedge clock_50); #1;
    chk("ov_valid_a", 40'(out_valid), 40'd1);
    chk("ov_flag_a", 40'(overrun), 40'd0);
    send_frame(2, 1'b1, 1'b0, W*H, "ovB");
    repeat (3) @(posedge clock_50); #1;
    chk("ov_flag_b", 40'(overrun), 40'd1);
    chk("ov_valid_b", 40'(out_valid), 40'd1);
    chk("ov_held", 40'(out_found), 40'(expect_of(vt[1], "x").found));
    out_ready = 1'b1;
    @(posedge clock_50); #1;
    chk("ov_drop", 40'(out_valid), 40'd0);

    // sof arriving at pixel index 10 restarts the frame there
    send_frame(4, 1'b1, 1'b0, 10, "part");
    chk("rs_before", 40'(resync), 40'd0);
    send_frame(1, 1'b1, 1'b1, W*H, "rs");
    repeat (4) @(posedge clock_50); #1;
    chk("rs_flag", 40'(resync), 40'd1);

    // reset mid-frame, then a frame with no sof starts at the origin
    send_frame(4, 1'b1, 1'b0, 12, "part2");
    reset = 1'b0; #1;
    chk("mr_in_ready", 40'(in_ready), 40'd0);
    chk("mr_out_valid", 40'(out_valid), 40'd0);
    chk("mr_overrun", 40'(overrun), 40'd0);
    chk("mr_resync", 40'(resync), 40'd0);
    @(posedge clock_50); #1;
    reset = 1'b1;
    @(posedge clock_50); #1;
    send_frame(0, 1'b0, 1'b1, W*H, "rst");

    for (int i = 0; i < 20 && q.size() != 0; i++) begin
      @(posedge clock_50); #1;
    end
    chk("queue_drained", 40'(q.size()), 40'd0);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nfail);
    $finish;
  end

endmodule
